// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver driven by a x OVS oversampling tick. The serial line is
//   passed through a two-flop synchroniser; a falling edge starts a frame,
//   the start bit is confirmed at mid-bit, DBIT data bits are shifted in
//   LSB first at OVS-tick spacing, and the stop bit is sampled at the end
//   of the SB_TICK-tick stop period.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   s_tick       oversampling tick, one clk cycle wide
//   dout         last received data word (held until the next frame completes)
//   rx_done_tick one-cycle strobe: frame complete, dout/frame_err valid
//   frame_err    stop bit was sampled low in the last completed frame
//   busy         high whenever the receiver is not idle
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OVS     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = $clog2((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s_reg, s_n;
  logic [NW-1:0]   n_reg, n_n;
  logic [DBIT-1:0] b_reg, b_n;
  logic [DBIT-1:0] dout_n;
  logic            ferr_n;
  logic            done_n;
  logic [1:0]      sync_q;
  logic            rx_s;

  assign rx_s = sync_q[1];
  assign busy = (state != IDLE);

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create order-dependent
  // races between the counters and the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // The synchroniser resets to the idle line level so that releasing
      // reset can never look like a start bit.
      sync_q       <= 2'b11;
      state        <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx};
      state        <= state_n;
      s_reg        <= s_n;
      n_reg        <= n_n;
      b_reg        <= b_n;
      dout         <= dout_n;
      frame_err    <= ferr_n;
      rx_done_tick <= done_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    s_n     = s_reg;
    n_n     = n_reg;
    b_n     = b_reg;
    dout_n  = dout;
    ferr_n  = frame_err;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        // Start detection is not gated by s_tick; a tick on this same edge
        // is therefore not counted.
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_reg == S_HALF) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              // Line went back high before mid start bit: glitch, drop it.
              state_n = IDLE;
            end
          end else begin
            s_n = s_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT) begin
            s_n = '0;
            b_n = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n_reg + 1'b1;
            end
          end else begin
            s_n = s_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP) begin
            dout_n  = b_reg;
            ferr_n  = ~rx_s;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s_reg + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled (default parameters).
// s_tick is high one clk in four, so one bit lasts 64 clk cycles. Frames are
// driven bit-serially; a monitor records every rx_done_tick, and a frame-level
// reference model predicts which strobes must appear and what they carry.
module tb_uart_rx_oversampled;

  localparam int BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;
  logic [1:0]  phase      = 2'd0;

  // Tick generator: one cycle high in every four.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      s_tick = (phase == 2'd3);
      phase  = phase + 2'd1;
    end
  end

  // Strobe monitor, sampled on the falling edge.
  logic [7:0]  got_data[$];
  logic        got_ferr[$];
  int unsigned got_cyc[$];
  int          long_pulse = 0;
  logic        prev_done  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        got_data.push_back(dout);
        got_ferr.push_back(frame_err);
        got_cyc.push_back(cyc);
        if (prev_done) long_pulse++;
      end
      prev_done = (rx_done_tick === 1'b1);
    end
  end

  // Reference model: the list of frames the receiver must report, plus the
  // values dout/frame_err must hold between frames.
  logic [7:0] exp_data[$];
  logic       exp_ferr[$];
  logic [7:0] last_dout = 8'h00;
  logic       last_ferr = 1'b0;

  task automatic expect_frame(input logic [7:0] data, input logic stop);
    exp_data.push_back(data);
    exp_ferr.push_back(!stop);
    last_dout = data;
    last_ferr = !stop;
    if (!stop) begin
      // The line is still low when the receiver goes idle, so the tail of
      // the bad stop bit is taken as a new start bit; with the line then
      // idling high, that frame reads all ones with a good stop bit.
      exp_data.push_back(8'hFF);
      exp_ferr.push_back(1'b0);
      last_dout = 8'hFF;
      last_ferr = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_count"}, got_data.size(), exp_data.size());
    while (got_data.size() > 0 && exp_data.size() > 0) begin
      check({tag, "_dout"}, got_data.pop_front(), exp_data.pop_front());
      check({tag, "_ferr"}, got_ferr.pop_front(), exp_ferr.pop_front());
    end
    got_data.delete();
    got_ferr.delete();
    got_cyc.delete();
    exp_data.delete();
    exp_ferr.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Start every frame in a fixed phase relative to s_tick.
  task automatic align_tick();
    while (s_tick !== 1'b1) idle(1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    align_tick();
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      idle(BIT_CYC);
    end
    rx = 1'b1;
  endtask

  logic [7:0] rnd_byte;
  int         gap;
  logic [9:0] part;

  initial begin
    // 1. Reset then idle
    reset = 1'b0;
    rx    = 1'b1;
    idle(3);
    check("rst_dout", dout, 8'h00);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    idle(2000);
    check_strobes("idle");
    check("idle_dout", dout, 8'h00);
    check("idle_busy", busy, 1'b0);

    // 2. Single frame
    send_frame(8'hA5, 1'b1);
    expect_frame(8'hA5, 1'b1);
    idle(BIT_CYC);
    check_strobes("single");
    check("single_hold", dout, last_dout);
    check("single_busy", busy, 1'b0);
    check("single_width", long_pulse, 0);

    // 3. Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    idle(BIT_CYC);
    if (got_cyc.size() == 2) check("b2b_spacing", got_cyc[1] - got_cyc[0], 10 * BIT_CYC);
    check_strobes("b2b");

    // 4. Start-bit glitch: 3 ticks low
    align_tick();
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(700);
    check_strobes("glitch");
    check("glitch_dout", dout, last_dout);
    check("glitch_ferr", frame_err, last_ferr);
    check("glitch_busy", busy, 1'b0);

    // 5. Framing error, then a good frame
    send_frame(8'h3C, 1'b0);
    expect_frame(8'h3C, 1'b0);
    idle(800);
    check_strobes("ferr");
    send_frame(8'h81, 1'b1);
    expect_frame(8'h81, 1'b1);
    idle(BIT_CYC);
    check_strobes("after_ferr");
    check("after_ferr_hold", frame_err, 1'b0);

    // 6. Reset in the middle of data bit 4 of 0x5A
    part = {1'b1, 8'h5A, 1'b0};
    align_tick();
    for (int i = 0; i < 5; i++) begin
      rx = part[i];
      idle(BIT_CYC);
    end
    rx = part[5];
    idle(BIT_CYC / 2);
    check("mid_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", rx_done_tick, 1'b0);
    idle(3);
    rx = 1'b1;
    reset = 1'b1;
    last_dout = 8'h00;
    last_ferr = 1'b0;
    idle(200);
    check_strobes("aborted");
    check("aborted_dout", dout, last_dout);
    send_frame(8'h12, 1'b1);
    expect_frame(8'h12, 1'b1);
    idle(BIT_CYC);
    check_strobes("after_rst");

    // 7. Randomised frames with random idle gaps
    for (int i = 0; i < 8; i++) begin
      rnd_byte = 8'($urandom);
      gap      = int'($urandom_range(0, 150));
      send_frame(rnd_byte, 1'b1);
      expect_frame(rnd_byte, 1'b1);
      idle(gap);
    end
    idle(BIT_CYC);
    check_strobes("random");
    check("random_hold", dout, last_dout);
    check("random_busy", busy, 1'b0);
    check("strobe_width", long_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
